// File: rtl/pop_counter_bank.sv
// pop_counter_bank
// Bank of NUM_CH independent pop counters, one per FIFO. Each channel counts
// pops with either wrap or saturate behaviour and keeps a sticky overflow
// flag. A single read port returns one channel per accepted request, one
// cycle after acceptance. Reads are only honoured while the system is idle.
// Optionally, an accepted read of a valid channel clears that channel.

module pop_counter_bank #(
    parameter int unsigned NUM_CH        = 4,
    parameter int unsigned CNT_W         = 5,
    parameter int unsigned IDX_W         = 2,
    parameter bit          SATURATE      = 1'b0,
    parameter bit          CLEAR_ON_READ = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] pop,
    input  logic              idle,
    input  logic              req,
    input  logic [IDX_W-1:0]  idx,
    output logic              valid_out,
    output logic [CNT_W-1:0]  count_out,
    output logic              ovf_out,
    output logic              err_out
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Per-channel counter and overflow state
    logic [CNT_W-1:0]  cnt_q [NUM_CH];
    logic [CNT_W-1:0]  cnt_d [NUM_CH];
    logic [NUM_CH-1:0] ovf_q;
    logic [NUM_CH-1:0] ovf_d;

    // Read decode
    logic              accept;
    logic              idx_ok;
    logic [31:0]       idx_ext;
    logic [NUM_CH-1:0] rd_hit;
    logic [NUM_CH-1:0] clr;
    logic [CNT_W-1:0]  sel_cnt;
    logic              sel_ovf;

    // Response registers
    logic              valid_q;
    logic              valid_d;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_d;
    logic              rovf_q;
    logic              rovf_d;
    logic              err_q;
    logic              err_d;

    // Requests while the system is busy are silently dropped.
    assign accept  = req & idle;
    assign idx_ext = 32'(idx);
    assign idx_ok  = (idx_ext < NUM_CH);

    // One-hot channel select for an accepted, in-range read; also picks the
    // pre-edge counter/flag of that channel for the response.
    always_comb begin
        rd_hit  = '0;
        sel_cnt = '0;
        sel_ovf = 1'b0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            if (accept && idx_ok && (idx_ext == 32'(i))) begin
                rd_hit[i] = 1'b1;
                sel_cnt   = cnt_q[i];
                sel_ovf   = ovf_q[i];
            end
        end
    end

    // Channels to clear this cycle; empty unless clear-on-read is built in.
    always_comb begin
        clr = '0;
        if (CLEAR_ON_READ) begin
            clr = rd_hit;
        end
    end

    // Next-state for every counter: clear first, then apply the pop so a pop
    // colliding with a clear still counts as the first word after the read.
    always_comb begin
        for (int i = 0; i < int'(NUM_CH); i++) begin
            cnt_d[i] = cnt_q[i];
            ovf_d[i] = ovf_q[i];
            if (clr[i]) begin
                cnt_d[i] = '0;
                ovf_d[i] = 1'b0;
            end
            if (pop[i]) begin
                if (clr[i]) begin
                    cnt_d[i] = CNT_ONE;
                end else if (cnt_q[i] == CNT_MAX) begin
                    ovf_d[i] = 1'b1;
                    if (!SATURATE) begin
                        cnt_d[i] = '0;
                    end
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_ONE;
                end
            end
        end
    end

    // Counter and overflow state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '{default: '0};
            ovf_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    // Response next-state: pulse valid on acceptance, otherwise hold the
    // last reported data so the consumer can still look at it.
    always_comb begin
        valid_d = 1'b0;
        count_d = count_q;
        rovf_d  = rovf_q;
        err_d   = err_q;
        if (accept) begin
            valid_d = 1'b1;
            if (idx_ok) begin
                count_d = sel_cnt;
                rovf_d  = sel_ovf;
                err_d   = 1'b0;
            end else begin
                count_d = '0;
                rovf_d  = 1'b0;
                err_d   = 1'b1;
            end
        end
    end

    // Response registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            count_q <= '0;
            rovf_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            count_q <= count_d;
            rovf_q  <= rovf_d;
            err_q   <= err_d;
        end
    end

    assign valid_out = valid_q;
    assign count_out = count_q;
    assign ovf_out   = rovf_q;
    assign err_out   = err_q;

endmodule

// File: tb/tb_pop_counter_bank.sv
// Directed bench for pop_counter_bank. Three instances share stimulus:
//   u_wrap : defaults (4 channels, 5-bit, wrap, no clear-on-read)
//   u_sat  : 4 channels, 5-bit, saturate
//   u_cor  : 3 channels, 5-bit, wrap, clear-on-read (idx 3 is out of range)

module tb_pop_counter_bank;

    logic       clk;
    logic       reset;
    logic [3:0] pop;
    logic       idle;
    logic       req;
    logic [1:0] idx;

    logic       w_valid, s_valid, c_valid;
    logic [4:0] w_count, s_count, c_count;
    logic       w_ovf, s_ovf, c_ovf;
    logic       w_err, s_err, c_err;

    int vectors;
    int miscompares;

    pop_counter_bank u_wrap (
        .clk(clk), .reset(reset), .pop(pop), .idle(idle), .req(req), .idx(idx),
        .valid_out(w_valid), .count_out(w_count), .ovf_out(w_ovf), .err_out(w_err)
    );

    pop_counter_bank #(.NUM_CH(4), .CNT_W(5), .IDX_W(2), .SATURATE(1'b1), .CLEAR_ON_READ(1'b0)) u_sat (
        .clk(clk), .reset(reset), .pop(pop), .idle(idle), .req(req), .idx(idx),
        .valid_out(s_valid), .count_out(s_count), .ovf_out(s_ovf), .err_out(s_err)
    );

    pop_counter_bank #(.NUM_CH(3), .CNT_W(5), .IDX_W(2), .SATURATE(1'b0), .CLEAR_ON_READ(1'b1)) u_cor (
        .clk(clk), .reset(reset), .pop(pop[2:0]), .idle(idle), .req(req), .idx(idx),
        .valid_out(c_valid), .count_out(c_count), .ovf_out(c_ovf), .err_out(c_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; pop = '0; req = 1'b0; idle = 1'b1; idx = '0;
        tick();
        reset = 1'b0;
    endtask

    task automatic pulse_pops(input logic [3:0] mask, input int n);
        for (int k = 0; k < n; k++) begin
            pop = mask;
            tick();
        end
        pop = '0;
    endtask

    // Single accepted read; on return the response is on the outputs.
    task automatic issue_read(input logic [1:0] sel);
        req = 1'b1; idle = 1'b1; idx = sel;
        tick();
        req = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; pop = 4'hF; req = 1'b1; idle = 1'b1; idx = 2'd0;
        repeat (3) tick();
        vectors++; if (w_valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid_wrap: got %b want 0", w_valid); end
        vectors++; if (w_count !== 5'd0) begin miscompares++; $display("FAIL rst_count_wrap: got %0d want 0", w_count); end
        reset = 1'b0; pop = '0; req = 1'b0;
        tick();
        vectors++; if ({w_valid, w_ovf, w_err} !== 3'b000) begin miscompares++; $display("FAIL rst_flags_wrap: got %b want 000", {w_valid, w_ovf, w_err}); end
        vectors++; if ({s_valid, s_ovf, s_err, s_count} !== 8'd0) begin miscompares++; $display("FAIL rst_all_sat: got %b want 0", {s_valid, s_ovf, s_err, s_count}); end
        vectors++; if ({c_valid, c_ovf, c_err, c_count} !== 8'd0) begin miscompares++; $display("FAIL rst_all_cor: got %b want 0", {c_valid, c_ovf, c_err, c_count}); end
        // Pops during reset must have been discarded.
        issue_read(2'd3);
        vectors++; if (w_count !== 5'd0) begin miscompares++; $display("FAIL rst_pop_discard: got %0d want 0", w_count); end
    endtask

    task automatic test_count();
        do_reset();
        pulse_pops(4'b0100, 7);
        issue_read(2'd2);
        vectors++; if (w_valid !== 1'b1) begin miscompares++; $display("FAIL cnt_valid: got %b want 1", w_valid); end
        vectors++; if (w_count !== 5'd7) begin miscompares++; $display("FAIL cnt_value: got %0d want 7", w_count); end
        vectors++; if ({w_ovf, w_err} !== 2'b00) begin miscompares++; $display("FAIL cnt_flags: got %b want 00", {w_ovf, w_err}); end
        vectors++; if (s_count !== 5'd7) begin miscompares++; $display("FAIL cnt_value_sat: got %0d want 7", s_count); end
        vectors++; if (c_count !== 5'd7) begin miscompares++; $display("FAIL cnt_value_cor: got %0d want 7", c_count); end
        tick();
        vectors++; if (w_valid !== 1'b0) begin miscompares++; $display("FAIL cnt_pulse_end: got %b want 0", w_valid); end
        vectors++; if (w_count !== 5'd7) begin miscompares++; $display("FAIL cnt_hold: got %0d want 7", w_count); end
    endtask

    task automatic test_wrap();
        do_reset();
        pulse_pops(4'b0001, 33);
        issue_read(2'd0);
        vectors++; if ({w_count, w_ovf} !== {5'd1, 1'b1}) begin miscompares++; $display("FAIL wrap_first: got cnt=%0d ovf=%b want cnt=1 ovf=1", w_count, w_ovf); end
        vectors++; if ({s_count, s_ovf} !== {5'd31, 1'b1}) begin miscompares++; $display("FAIL wrap_sat_ch0: got cnt=%0d ovf=%b want cnt=31 ovf=1", s_count, s_ovf); end
        vectors++; if ({c_count, c_ovf} !== {5'd1, 1'b1}) begin miscompares++; $display("FAIL wrap_cor_first: got cnt=%0d ovf=%b want cnt=1 ovf=1", c_count, c_ovf); end
        issue_read(2'd0);
        vectors++; if ({w_valid, w_count, w_ovf} !== {1'b1, 5'd1, 1'b1}) begin miscompares++; $display("FAIL wrap_second: got v=%b cnt=%0d ovf=%b want v=1 cnt=1 ovf=1", w_valid, w_count, w_ovf); end
        vectors++; if ({c_count, c_ovf} !== {5'd0, 1'b0}) begin miscompares++; $display("FAIL wrap_cor_cleared: got cnt=%0d ovf=%b want cnt=0 ovf=0", c_count, c_ovf); end
    endtask

    task automatic test_saturate();
        do_reset();
        pulse_pops(4'b1000, 40);
        issue_read(2'd3);
        vectors++; if ({s_count, s_ovf} !== {5'd31, 1'b1}) begin miscompares++; $display("FAIL sat_ch3: got cnt=%0d ovf=%b want cnt=31 ovf=1", s_count, s_ovf); end
        vectors++; if ({w_count, w_ovf} !== {5'd8, 1'b1}) begin miscompares++; $display("FAIL sat_wrap_ch3: got cnt=%0d ovf=%b want cnt=8 ovf=1", w_count, w_ovf); end
        issue_read(2'd1);
        vectors++; if ({s_valid, s_count, s_ovf} !== {1'b1, 5'd0, 1'b0}) begin miscompares++; $display("FAIL sat_ch1: got v=%b cnt=%0d ovf=%b want v=1 cnt=0 ovf=0", s_valid, s_count, s_ovf); end
    endtask

    task automatic test_idle_gating();
        do_reset();
        pulse_pops(4'b0010, 5);
        req = 1'b1; idle = 1'b0; idx = 2'd1;
        tick();
        vectors++; if ({w_valid, c_valid} !== 2'b00) begin miscompares++; $display("FAIL idle_drop_valid: got %b want 00", {w_valid, c_valid}); end
        idx = 2'd3;
        tick();
        req = 1'b0; idle = 1'b1;
        vectors++; if ({c_valid, c_err} !== 2'b00) begin miscompares++; $display("FAIL idle_drop_err: got %b want 00", {c_valid, c_err}); end
        issue_read(2'd1);
        vectors++; if (c_count !== 5'd5) begin miscompares++; $display("FAIL idle_no_clear: got %0d want 5", c_count); end
        vectors++; if (w_count !== 5'd5) begin miscompares++; $display("FAIL idle_wrap_cnt: got %0d want 5", w_count); end
    endtask

    task automatic test_clear_collision();
        do_reset();
        pulse_pops(4'b0010, 5);
        pop = 4'b0010; req = 1'b1; idle = 1'b1; idx = 2'd1;
        tick();
        pop = '0; req = 1'b0;
        vectors++; if ({c_valid, c_count, c_ovf} !== {1'b1, 5'd5, 1'b0}) begin miscompares++; $display("FAIL coll_resp: got v=%b cnt=%0d ovf=%b want v=1 cnt=5 ovf=0", c_valid, c_count, c_ovf); end
        vectors++; if (w_count !== 5'd5) begin miscompares++; $display("FAIL coll_wrap_resp: got %0d want 5", w_count); end
        issue_read(2'd1);
        vectors++; if (c_count !== 5'd1) begin miscompares++; $display("FAIL coll_next: got %0d want 1", c_count); end
        vectors++; if (w_count !== 5'd6) begin miscompares++; $display("FAIL coll_wrap_next: got %0d want 6", w_count); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        pulse_pops(4'b0111, 2);
        pulse_pops(4'b0011, 1);
        pulse_pops(4'b0001, 2);
        req = 1'b1; idle = 1'b1; idx = 2'd0;
        tick();
        vectors++; if ({w_valid, w_count} !== {1'b1, 5'd5}) begin miscompares++; $display("FAIL b2b_ch0: got v=%b cnt=%0d want v=1 cnt=5", w_valid, w_count); end
        idx = 2'd1;
        tick();
        vectors++; if ({w_valid, w_count} !== {1'b1, 5'd3}) begin miscompares++; $display("FAIL b2b_ch1: got v=%b cnt=%0d want v=1 cnt=3", w_valid, w_count); end
        idx = 2'd2;
        tick();
        vectors++; if ({w_valid, w_count, c_count} !== {1'b1, 5'd2, 5'd2}) begin miscompares++; $display("FAIL b2b_ch2: got v=%b cnt=%0d cor=%0d want v=1 cnt=2 cor=2", w_valid, w_count, c_count); end
        idx = 2'd3;
        tick();
        req = 1'b0;
        vectors++; if ({w_valid, w_count, w_err} !== {1'b1, 5'd0, 1'b0}) begin miscompares++; $display("FAIL b2b_ch3: got v=%b cnt=%0d err=%b want v=1 cnt=0 err=0", w_valid, w_count, w_err); end
        vectors++; if ({c_valid, c_count, c_ovf, c_err} !== {1'b1, 5'd0, 1'b0, 1'b1}) begin miscompares++; $display("FAIL b2b_err: got v=%b cnt=%0d ovf=%b err=%b want v=1 cnt=0 ovf=0 err=1", c_valid, c_count, c_ovf, c_err); end
        tick();
        vectors++; if ({w_valid, c_valid, c_err} !== 3'b001) begin miscompares++; $display("FAIL b2b_end: got %b want 001", {w_valid, c_valid, c_err}); end
    endtask

    task automatic test_reset_mid_stream();
        pulse_pops(4'b0001, 4);
        req = 1'b1; idle = 1'b1; idx = 2'd0;
        tick();
        vectors++; if ({w_valid, w_count} !== {1'b1, 5'd9}) begin miscompares++; $display("FAIL mid_first: got v=%b cnt=%0d want v=1 cnt=9", w_valid, w_count); end
        idx = 2'd1; reset = 1'b1; pop = 4'hF;
        tick();
        reset = 1'b0; pop = '0; req = 1'b0;
        vectors++; if ({w_valid, w_count, w_ovf, w_err} !== 8'd0) begin miscompares++; $display("FAIL mid_second: got %b want 0", {w_valid, w_count, w_ovf, w_err}); end
        for (int i = 0; i < 4; i++) begin
            issue_read(2'(i));
            vectors++; if ({w_count, w_ovf} !== 6'd0) begin miscompares++; $display("FAIL mid_after_ch%0d: got cnt=%0d ovf=%b want 0", i, w_count, w_ovf); end
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        reset = 1'b1; pop = '0; idle = 1'b1; req = 1'b0; idx = '0;
        test_reset();
        test_count();
        test_wrap();
        test_saturate();
        test_idle_gating();
        test_clear_collision();
        test_back_to_back();
        test_reset_mid_stream();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pop_counter_bank.md
# pop_counter_bank

Parametrised bank of per-channel pop counters that sits beside the FIFO array and counts words leaving each FIFO. Each channel has its own counter with wrap or saturate mode, a sticky overflow flag and optional clear-on-read. The probe reads one channel at a time through a `req`/`idx` interface, allowed only while the system reports `idle`. It generalises the fixed four-FIFO, 5-bit counter block to any channel count and width.

## Interface
- `NUM_CH`, 4: number of counted channels (1..16).
- `CNT_W`, 5: counter width in bits (1..16).
- `IDX_W`, 2: width of `idx`; must satisfy 2^IDX_W >= NUM_CH.
- `SATURATE`, 0: 0 = counters wrap modulo 2^CNT_W; 1 = counters hold at 2^CNT_W-1.
- `CLEAR_ON_READ`, 0: 1 = an accepted read of a valid channel zeroes its counter and its overflow flag.

Ports:
- `clk`, input, 1: clock; all logic on the rising edge.
- `reset`, input, 1: synchronous, active-high.
- `pop`, input, NUM_CH: bit i pulses once per word popped from FIFO i.
- `idle`, input, 1: system idle; reads are accepted only when this is 1.
- `req`, input, 1: read request, sampled every cycle.
- `idx`, input, IDX_W: channel selected for the read.
- `valid_out`, output, 1: one-cycle pulse marking a read response.
- `count_out`, output, CNT_W: counter value reported by the response.
- `ovf_out`, output, 1: overflow flag of the reported channel.
- `err_out`, output, 1: the response is for an out-of-range `idx`.

## Operation
- Reset (any cycle, including mid-read): all counters, overflow flags, `valid_out`, `count_out`, `ovf_out` and `err_out` go to 0 on the next edge. Pops and reads in that cycle are discarded.
- Counting: each cycle with `pop[i]`=1, counter i increments by 1. All channels are independent; pops on several channels in the same cycle all count.
- Wrap mode (`SATURATE`=0): the increment that moves a counter from 2^CNT_W-1 to 0 also sets overflow flag i.
- Saturate mode (`SATURATE`=1): a counter at 2^CNT_W-1 holds its value. A pop at that value sets overflow flag i.
- Overflow flags are sticky until reset, or until a clear-on-read of that channel.
- Read acceptance: a read is accepted when `req`=1 and `idle`=1. A request with `idle`=0 is dropped, with no response and no side effect; it is not queued.
- Response to an accepted read:
  - Valid channel (`idx` < NUM_CH): `count_out` and `ovf_out` take counter and flag `idx` as they were before this edge (that cycle's pop is excluded), `err_out`=0.
  - Out-of-range `idx` (`idx` >= NUM_CH): `count_out`=0, `ovf_out`=0, `err_out`=1. Counters are untouched.
- Clear-on-read (`CLEAR_ON_READ`=1, valid `idx`):
  - Counter and flag `idx` are cleared on the acceptance edge.
  - A pop on that channel in the same cycle is not lost: the counter becomes 1 and the flag becomes 0.
- Between responses, `count_out`, `ovf_out` and `err_out` hold the last reported values.

## Timing
- Read latency is 1 cycle: a read accepted at edge N gives `valid_out`=1 for the cycle after edge N, and `valid_out` returns to 0 at edge N+1 unless another read is accepted.
- Throughput is one read per cycle. Back-to-back accepted requests give consecutive `valid_out` pulses, each reflecting its own `idx`.
- Pop-to-count latency is 1 cycle: a pop sampled at edge N is visible to a read accepted at edge N+1 or later.
- There is no backpressure; the consumer must take each response in its pulse cycle.
- Counter width arithmetic is exactly CNT_W bits, with no hidden extra bits.

## Test plan
- Reset then count (defaults): 7 pops on ch2, then read idx=2 with idle=1 -> one-cycle `valid_out`, `count_out`=7, `ovf_out`=0, `err_out`=0. All outputs are 0 right after reset.
- Wrap: CNT_W=5, 33 pops on ch0, then read -> `count_out`=1, `ovf_out`=1. A second read returns the same values.
- Saturate: `SATURATE`=1, 40 pops on ch3 -> `count_out`=31, `ovf_out`=1. Ch1 with no pops reads `count_out`=0, `ovf_out`=0.
- Idle gating and errors: `req` with idle=0 -> no `valid_out`. NUM_CH=3 with idx=3 -> `valid_out`=1, `err_out`=1, `count_out`=0.
- Clear-on-read collision: `CLEAR_ON_READ`=1, ch1=5, read idx=1 while `pop[1]`=1 in the same cycle -> response `count_out`=5. A next read gives `count_out`=1.
- Reset mid-stream: back-to-back reads with reset asserted on the second request -> no second `valid_out`, and all counters read 0 afterwards.
